// File: rtl/rs_issue_queue_pkg.sv
// Shared types for the reservation station: entry payload, FU class and opcode constants.
// Operand/tag/ROB widths are fixed here because the packed entry type depends on them.
package rs_issue_queue_pkg;

    localparam int unsigned PREG_W = 6;
    localparam int unsigned ROB_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic {
        FU_ALU = 1'b0,
        FU_MEM = 1'b1
    } fu_class_e;

    typedef struct packed {
        logic [6:0]        op;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [PREG_W-1:0] dest;
        logic [PREG_W-1:0] src_tag_1;
        logic [DATA_W-1:0] src_data_1;
        logic              src_rdy_1;
        logic [PREG_W-1:0] src_tag_2;
        logic [DATA_W-1:0] src_data_2;
        logic              src_rdy_2;
        logic              imm_src2;
        logic [ROB_W-1:0]  rob_idx;
        fu_class_e         fu_class;
    } rs_entry_t;

    // Tag 0 is the hardwired zero register and an immediate src2 needs no producer.
    function automatic rs_entry_t normalize_entry(input rs_entry_t e);
        rs_entry_t r;
        r = e;
        if (e.src_tag_1 == '0) r.src_rdy_1 = 1'b1;
        if (e.src_tag_2 == '0 || e.imm_src2) r.src_rdy_2 = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first picker: grants up to PORTS eligible entries, port k getting the k-th oldest.
// older[i][j] = 1 means entry j is older than entry i.
module rs_age_select
    import rs_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PORTS = 2
) (
    input  logic [DEPTH-1:0]            eligible,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [PORTS-1:0][DEPTH-1:0] grant
);

    // An entry's rank is the number of eligible entries older than it; ranks are unique.
    always_comb begin
        int unsigned rank;
        grant = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rank = $countones(eligible & older[i]);
            for (int unsigned p = 0; p < PORTS; p++) begin
                grant[p][i] = eligible[i] && (rank == p);
            end
        end
    end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station with operand wakeup/bypass and age-ordered issue to ALU ports
// plus one MEM port. Issue outputs depend on registered state only.
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DISP_W  = 2,
    parameter int unsigned ISSUE_W = 3,
    parameter int unsigned WAKE_W  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [DISP_W-1:0]                   disp_valid,
    input  rs_entry_t [DISP_W-1:0]              disp_entry,
    output logic                                disp_ready,
    input  logic [WAKE_W-1:0]                   wake_valid,
    input  logic [WAKE_W-1:0][PREG_W-1:0]       wake_tag,
    input  logic [WAKE_W-1:0][DATA_W-1:0]       wake_data,
    output logic [ISSUE_W-1:0]                  iss_valid,
    output rs_entry_t [ISSUE_W-1:0]             iss_entry,
    input  logic [ISSUE_W-1:0]                  iss_ready,
    output logic [$clog2(DEPTH):0]              occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]                valid_q;
    rs_entry_t [DEPTH-1:0]           ent_q;
    logic [DEPTH-1:0][DEPTH-1:0]     older_q;
    logic [OCC_W-1:0]                occ_q;

    logic [DEPTH-1:0]                elig_alu, elig_mem, freed;
    logic [ISSUE_W-2:0][DEPTH-1:0]   grant_alu;
    logic [0:0][DEPTH-1:0]           grant_mem;
    logic [ISSUE_W-1:0][DEPTH-1:0]   grant;
    logic [DISP_W-1:0]               alloc_en;
    logic [DISP_W-1:0][IDX_W-1:0]    alloc_idx;
    logic [DISP_W-1:0][DEPTH-1:0]    alloc_row;
    logic [OCC_W-1:0]                n_alloc, n_free;

    // Lowest wake port wins when several carry the same tag; tag 0 never wakes.
    function automatic rs_entry_t apply_wake(input rs_entry_t e,
                                             input logic [WAKE_W-1:0] wv,
                                             input logic [WAKE_W-1:0][PREG_W-1:0] wt,
                                             input logic [WAKE_W-1:0][DATA_W-1:0] wd);
        rs_entry_t r;
        r = e;
        for (int unsigned w = 0; w < WAKE_W; w++) begin
            if (wv[w] && wt[w] != '0) begin
                if (!r.src_rdy_1 && r.src_tag_1 == wt[w]) begin
                    r.src_rdy_1  = 1'b1;
                    r.src_data_1 = wd[w];
                end
                if (!r.src_rdy_2 && r.src_tag_2 == wt[w]) begin
                    r.src_rdy_2  = 1'b1;
                    r.src_data_2 = wd[w];
                end
            end
        end
        return r;
    endfunction

    assign disp_ready = occ_q <= OCC_W'(DEPTH - DISP_W);
    assign occupancy  = occ_q;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            elig_alu[i] = valid_q[i] && ent_q[i].src_rdy_1 && ent_q[i].src_rdy_2 &&
                          ent_q[i].fu_class == FU_ALU;
            elig_mem[i] = valid_q[i] && ent_q[i].src_rdy_1 && ent_q[i].src_rdy_2 &&
                          ent_q[i].fu_class == FU_MEM;
        end
    end

    rs_age_select #(.DEPTH(DEPTH), .PORTS(ISSUE_W - 1)) u_alu_sel (
        .eligible (elig_alu),
        .older    (older_q),
        .grant    (grant_alu)
    );

    rs_age_select #(.DEPTH(DEPTH), .PORTS(1)) u_mem_sel (
        .eligible (elig_mem),
        .older    (older_q),
        .grant    (grant_mem)
    );

    assign grant = {grant_mem, grant_alu};

    always_comb begin
        iss_valid = '0;
        iss_entry = '0;
        freed     = '0;
        for (int unsigned p = 0; p < ISSUE_W; p++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (grant[p][i]) begin
                    iss_valid[p] = 1'b1;
                    iss_entry[p] = ent_q[i];
                    freed[i]     = freed[i] | iss_ready[p];
                end
            end
        end
        n_free = OCC_W'($countones(freed));
    end

    // Free slots come from start-of-cycle valid bits, so same-cycle issues are not reused.
    always_comb begin
        logic [DEPTH-1:0] taken;
        taken     = '0;
        alloc_en  = '0;
        alloc_idx = '0;
        alloc_row = '0;
        for (int unsigned s = 0; s < DISP_W; s++) begin
            alloc_row[s] = valid_q | taken;
            if (disp_ready && disp_valid[s]) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (!alloc_en[s] && !valid_q[i] && !taken[i]) begin
                        alloc_en[s]  = 1'b1;
                        alloc_idx[s] = IDX_W'(i);
                        taken[i]     = 1'b1;
                    end
                end
            end
        end
        n_alloc = OCC_W'($countones(alloc_en));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
            older_q <= '0;
            occ_q   <= '0;
        end else begin
            occ_q <= occ_q + n_alloc - n_free;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (freed[i]) begin
                    valid_q[i] <= 1'b0;
                end else if (valid_q[i]) begin
                    ent_q[i] <= apply_wake(ent_q[i], wake_valid, wake_tag, wake_data);
                end
            end
            // Clear every column first so the row writes below can mark earlier slots older.
            for (int unsigned s = 0; s < DISP_W; s++) begin
                if (alloc_en[s]) begin
                    for (int unsigned x = 0; x < DEPTH; x++) begin
                        older_q[x][alloc_idx[s]] <= 1'b0;
                    end
                end
            end
            for (int unsigned s = 0; s < DISP_W; s++) begin
                if (alloc_en[s]) begin
                    valid_q[alloc_idx[s]] <= 1'b1;
                    older_q[alloc_idx[s]] <= alloc_row[s];
                    ent_q[alloc_idx[s]]   <= apply_wake(normalize_entry(disp_entry[s]),
                                                        wake_valid, wake_tag, wake_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: an age-ordered queue model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_rs_issue_queue;
    import rs_issue_queue_pkg::*;

    localparam int DEPTH   = 16;
    localparam int DISP_W  = 2;
    localparam int ISSUE_W = 3;
    localparam int WAKE_W  = 3;

    logic                            clk;
    logic                            rst, flush;
    logic [DISP_W-1:0]               disp_valid;
    rs_entry_t [DISP_W-1:0]          disp_entry;
    logic                            disp_ready;
    logic [WAKE_W-1:0]               wake_valid;
    logic [WAKE_W-1:0][PREG_W-1:0]   wake_tag;
    logic [WAKE_W-1:0][DATA_W-1:0]   wake_data;
    logic [ISSUE_W-1:0]              iss_valid;
    rs_entry_t [ISSUE_W-1:0]         iss_entry;
    logic [ISSUE_W-1:0]              iss_ready;
    logic [$clog2(DEPTH):0]          occupancy;

    rs_issue_queue #(
        .DEPTH   (DEPTH),
        .DISP_W  (DISP_W),
        .ISSUE_W (ISSUE_W),
        .WAKE_W  (WAKE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_entry (disp_entry),
        .disp_ready (disp_ready),
        .wake_valid (wake_valid),
        .wake_tag   (wake_tag),
        .wake_data  (wake_data),
        .iss_valid  (iss_valid),
        .iss_entry  (iss_entry),
        .iss_ready  (iss_ready),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: queue kept in dispatch (age) order ----------------
    rs_entry_t          mq[$];
    rs_entry_t          nq[$];
    bit                 model_on = 0;
    logic [ISSUE_W-1:0] ev;
    rs_entry_t          ee[ISSUE_W];
    int                 qi[ISSUE_W];

    function automatic rs_entry_t m_norm(input rs_entry_t e);
        rs_entry_t r = e;
        r.src_rdy_1 = e.src_rdy_1 | (e.src_tag_1 == 0);
        r.src_rdy_2 = e.src_rdy_2 | (e.src_tag_2 == 0) | e.imm_src2;
        return r;
    endfunction

    function automatic rs_entry_t m_wake(input rs_entry_t e);
        rs_entry_t r = e;
        for (int w = 0; w < WAKE_W; w++) begin
            if (wake_valid[w] && wake_tag[w] != 0) begin
                if (!r.src_rdy_1 && r.src_tag_1 == wake_tag[w]) begin
                    r.src_rdy_1 = 1'b1; r.src_data_1 = wake_data[w];
                end
                if (!r.src_rdy_2 && r.src_tag_2 == wake_tag[w]) begin
                    r.src_rdy_2 = 1'b1; r.src_data_2 = wake_data[w];
                end
            end
        end
        return r;
    endfunction

    // Walk oldest to youngest: ALU ops fill ports 0..ISSUE_W-2, first MEM op takes the last port.
    function automatic void m_select();
        int nalu = 0;
        ev = '0;
        for (int p = 0; p < ISSUE_W; p++) begin ee[p] = '0; qi[p] = -1; end
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].src_rdy_1 && mq[i].src_rdy_2) begin
                if (mq[i].fu_class == FU_MEM) begin
                    if (!ev[ISSUE_W-1]) begin
                        ev[ISSUE_W-1] = 1'b1; ee[ISSUE_W-1] = mq[i]; qi[ISSUE_W-1] = i;
                    end
                end else if (nalu < ISSUE_W - 1) begin
                    ev[nalu] = 1'b1; ee[nalu] = mq[i]; qi[nalu] = i;
                    nalu++;
                end
            end
        end
    endfunction

    initial begin
        rs_entry_t exp_e;
        int        start_sz;
        bit        drop;
        forever begin
            @(negedge clk);
            if (model_on) begin
                m_select();
                check("iss_valid", iss_valid, ev);
                for (int p = 0; p < ISSUE_W; p++) begin
                    exp_e = ev[p] ? ee[p] : '0;
                    check($sformatf("iss_entry[%0d]", p), iss_entry[p], exp_e);
                end
                check("occupancy", occupancy, mq.size());
                check("disp_ready", disp_ready, mq.size() <= DEPTH - DISP_W);
                check("occ_bound", occupancy <= DEPTH, 1'b1);
            end
            @(posedge clk);
            if (rst || flush) begin
                mq.delete();
                model_on = 1;
            end else if (model_on) begin
                m_select();
                start_sz = mq.size();
                nq.delete();
                for (int i = 0; i < mq.size(); i++) begin
                    drop = 0;
                    for (int p = 0; p < ISSUE_W; p++)
                        if (ev[p] && qi[p] == i && iss_ready[p]) drop = 1;
                    if (!drop) nq.push_back(m_wake(mq[i]));
                end
                if (start_sz <= DEPTH - DISP_W)
                    for (int s = 0; s < DISP_W; s++)
                        if (disp_valid[s]) nq.push_back(m_wake(m_norm(disp_entry[s])));
                mq = nq;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic rs_entry_t mk(input logic [6:0] op, input fu_class_e cls,
                                     input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                                     input logic [5:0] t2, input logic r2, input logic [31:0] d2,
                                     input logic imm, input logic [3:0] rob);
        rs_entry_t e = '0;
        e.op = op; e.fu_class = cls; e.dest = 6'(rob) + 6'd40;
        e.src_tag_1 = t1; e.src_rdy_1 = r1; e.src_data_1 = d1;
        e.src_tag_2 = t2; e.src_rdy_2 = r2; e.src_data_2 = d2;
        e.imm_src2 = imm; e.rob_idx = rob;
        return e;
    endfunction

    function automatic rs_entry_t addi(input logic [31:0] imm, input logic [3:0] rob);
        return mk(OP_IMM, FU_ALU, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, imm, 1'b1, rob);
    endfunction

    function automatic rs_entry_t alu_wait(input logic [5:0] tag, input logic [3:0] rob);
        return mk(OP_REG, FU_ALU, tag, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3, 1'b0, rob);
    endfunction

    function automatic rs_entry_t load(input logic [3:0] rob);
        return mk(OP_LOAD, FU_MEM, 6'd0, 1'b1, 32'h100 + 32'(rob), 6'd0, 1'b0, 32'd8, 1'b1, rob);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; disp_valid = '0; wake_valid = '0;
    endtask

    task automatic run_flush_case(input bit use_rst);
        disp_valid = 2'b11; disp_entry[0] = alu_wait(6'd50, 4'd0); disp_entry[1] = alu_wait(6'd50, 4'd1);
        cyc();
        disp_valid = 2'b11; disp_entry[0] = alu_wait(6'd50, 4'd2); disp_entry[1] = alu_wait(6'd50, 4'd3);
        cyc();
        disp_valid = 2'b01; disp_entry[0] = alu_wait(6'd50, 4'd4);
        cyc();
        @(negedge clk);
        check("lit_pre_flush_occ", occupancy, 5);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        disp_valid = 2'b11; disp_entry[0] = addi(32'd1, 4'd5); disp_entry[1] = addi(32'd2, 4'd6);
        cyc();
        @(negedge clk);
        check(use_rst ? "lit_rst_occ" : "lit_flush_occ", occupancy, 0);
        check(use_rst ? "lit_rst_iss" : "lit_flush_iss", iss_valid, 3'b000);
        check(use_rst ? "lit_rst_rdy" : "lit_flush_rdy", disp_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = '0; disp_entry = '0;
        wake_valid = '0; wake_tag = '0; wake_data = '0; iss_ready = '1;
        cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        check("lit_reset_occ", occupancy, 0);
        check("lit_reset_rdy", disp_ready, 1'b1);
        check("lit_reset_iss", iss_valid, 3'b000);
        check("lit_reset_entry", iss_entry, '0);

        // Two ADDIs: both issue together next cycle, oldest on port 0.
        disp_valid = 2'b11; disp_entry[0] = addi(32'd5, 4'd0); disp_entry[1] = addi(32'd7, 4'd1);
        cyc();
        @(negedge clk);
        check("lit_addi_valid", iss_valid, 3'b011);
        check("lit_addi_p0_imm", iss_entry[0].src_data_2, 32'd5);
        check("lit_addi_p1_imm", iss_entry[1].src_data_2, 32'd7);
        check("lit_addi_occ", occupancy, 2);
        cyc();
        @(negedge clk);
        check("lit_addi_drain", occupancy, 0);

        // Wakeup in cycle N allows issue only in N+1.
        disp_valid = 2'b01; disp_entry[0] = alu_wait(6'd12, 4'd5);
        cyc();
        wake_valid = 3'b001; wake_tag[0] = 6'd12; wake_data[0] = 32'h2A;
        @(negedge clk);
        check("lit_wake_same_cycle", iss_valid, 3'b000);
        cyc();
        @(negedge clk);
        check("lit_wake_valid", iss_valid, 3'b001);
        check("lit_wake_data", iss_entry[0].src_data_1, 32'h2A);
        cyc();

        // Dispatch bypass; two wake ports carry tag 9, the lower one supplies the data.
        disp_valid = 2'b01; disp_entry[0] = alu_wait(6'd9, 4'd6);
        wake_valid = 3'b110; wake_tag[1] = 6'd9; wake_data[1] = 32'h99;
        wake_tag[2] = 6'd9; wake_data[2] = 32'h55;
        cyc();
        @(negedge clk);
        check("lit_bypass_valid", iss_valid, 3'b001);
        check("lit_bypass_data", iss_entry[0].src_data_1, 32'h99);
        cyc();

        // Fill to DEPTH with waiting ops, then drain two and watch disp_ready.
        for (int k = 0; k < 8; k++) begin
            disp_valid = 2'b11;
            disp_entry[0] = alu_wait(6'(20 + 2 * k), 4'(2 * k));
            disp_entry[1] = alu_wait(6'(21 + 2 * k), 4'(2 * k + 1));
            cyc();
        end
        @(negedge clk);
        check("lit_full_occ", occupancy, 16);
        check("lit_full_rdy", disp_ready, 1'b0);
        disp_valid = 2'b11; disp_entry[0] = alu_wait(6'd60, 4'd0); disp_entry[1] = alu_wait(6'd60, 4'd1);
        wake_valid = 3'b001; wake_tag[0] = 6'd20; wake_data[0] = 32'd1;
        cyc();
        @(negedge clk);
        check("lit_held_not_written", occupancy, 16);
        check("lit_full_issue", iss_valid, 3'b001);
        disp_valid = 2'b11;
        wake_valid = 3'b001; wake_tag[0] = 6'd21; wake_data[0] = 32'd2;
        cyc();
        @(negedge clk);
        check("lit_occ15", occupancy, 15);
        check("lit_occ15_rdy", disp_ready, 1'b0);
        disp_valid = 2'b11;
        cyc();
        @(negedge clk);
        check("lit_occ14", occupancy, 14);
        check("lit_occ14_rdy", disp_ready, 1'b1);
        flush = 1'b1;
        cyc();
        @(negedge clk);
        check("lit_fill_flush", occupancy, 0);

        // Loads under MEM-port backpressure.
        iss_ready = 3'b011;
        disp_valid = 2'b11; disp_entry[0] = load(4'd1); disp_entry[1] = load(4'd2);
        cyc();
        @(negedge clk);
        check("lit_ld_c1_valid", iss_valid, 3'b100);
        check("lit_ld_c1_rob", iss_entry[2].rob_idx, 4'd1);
        disp_valid = 2'b11; disp_entry[0] = load(4'd3); disp_entry[1] = addi(32'd9, 4'd4);
        cyc();
        @(negedge clk);
        check("lit_ld_c2_valid", iss_valid, 3'b101);
        check("lit_ld_c2_rob", iss_entry[2].rob_idx, 4'd1);
        check("lit_ld_c2_alu", iss_entry[0].fu_class, FU_ALU);
        cyc();
        @(negedge clk);
        check("lit_ld_c3_rob", iss_entry[2].rob_idx, 4'd1);
        check("lit_ld_c3_valid", iss_valid, 3'b100);
        iss_ready = 3'b111;
        cyc();
        @(negedge clk);
        check("lit_ld_c4_rob", iss_entry[2].rob_idx, 4'd2);
        cyc();
        @(negedge clk);
        check("lit_ld_c5_rob", iss_entry[2].rob_idx, 4'd3);
        cyc();
        @(negedge clk);
        check("lit_ld_drain", occupancy, 0);

        // Flush and mid-run reset each drop the live entries and the same-cycle dispatch.
        run_flush_case(1'b0);
        run_flush_case(1'b1);
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
